lag_capture: RTL and testbench
==============================

// Module: lag_capture
// PURPOSE
//  Consumes bcdcounter's 20-bit BCD count (5 digits, 0.01 ms/LSB) in the 27 MHz 'clock' domain.
//  Debounces the photo SENSOR and latches the count on the first flash after each test-frame start.
//  Publishes last lag, timeout, sample count and (optional) min/max to the display/OSD path.
// PARAMETERS
//  DEBOUNCE_CYCLES    27  sensor must be stable this many clocks (1 us) before a level is accepted
//  SENSOR_ACTIVE_LOW  1   1: sensor pin low = light detected; 0: high = light
//  TIMEOUT_BCD        20'h99999  count at/above which an armed measurement times out
// PORTS
//  clock         in   1   27 MHz system clock
//  reset         in   1   asynchronous, active-high reset
//  start         in   1   one-cycle pulse, new test frame (same pulse that resets bcdcounter)
//  sensor        in   1   raw asynchronous sensor pin
//  bcdcount      in   20  running BCD lag count from bcdcounter
//  lag_bcd       out  20  last captured lag, BCD
//  lag_valid     out  1   one-cycle pulse when lag_bcd updates
//  timeout       out  1   sticky: last measurement timed out; cleared by next start
//  busy          out  1   high while ARMED or WAIT_RELEASE
//  sample_count  out  8   number of valid captures since reset, saturates at 255
//  min_bcd       out  20  minimum captured lag (LAG_MINMAX_EN only)
//  max_bcd       out  20  maximum captured lag (LAG_MINMAX_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; lag_bcd=0, lag_valid=0, timeout=0, busy=0, sample_count=0,
//    min_bcd=20'h99999, max_bcd=0; debounced level = inactive.
//  - Sensor path: 2-FF synchroniser, polarity normalise to 'light'.
//    Debounce counter reloads on any change; level accepted after DEBOUNCE_CYCLES equal samples.
//  - Fixed pipeline bias: 2 + DEBOUNCE_CYCLES clocks, ~1.07 us < 1 LSB. Not compensated.
//  - FSM states:
//    IDLE: wait start.
//    On start: if light=1 -> WAIT_RELEASE, else -> ARMED.
//    WAIT_RELEASE: light=0 -> ARMED (count keeps running; lag still measured from start).
//    ARMED: on light rising (0->1 of debounced level):
//      lag_bcd<=bcdcount; lag_valid=1 next cycle; sample_count++; -> DONE.
//    ARMED/WAIT_RELEASE: bcdcount>=TIMEOUT_BCD -> timeout<=1, no capture -> DONE.
//    DONE: wait start (same as IDLE; lag_bcd held).
//  - start in any state restarts: clears timeout, goes to ARMED/WAIT_RELEASE.
//    start beats a same-cycle capture or timeout (no capture, no lag_valid).
//  - Compares are plain unsigned on the 20-bit BCD vector (digit order makes this exact).
//  - Capture uses the bcdcount value present in the cycle the debounced edge is seen.
//  - Extra flashes in DONE are ignored; only one capture per start.
//  - Asynchronous reset mid-measurement: all state to reset values immediately.
// CONFIGURATION
//  LAG_MINMAX_EN defined:
//    - On each capture: min_bcd<=min(min_bcd,lag_bcd_new); max_bcd<=max(max_bcd,lag_bcd_new).
//    - Both update in the same cycle as lag_bcd.
//    - Timeouts never update min/max.
//  LAG_MINMAX_EN undefined:
//    - Comparators and registers removed.
//    - min_bcd/max_bcd tied to constant 0; ports stay present.
// STRUCTURE
//  lag_pkg (shared):
//    - localparam BCD_MAX=20'h99999.
//    - typedef enum {IDLE,WAIT_RELEASE,ARMED,DONE} lag_state_t.
//    - SAMPLE_MAX=8'd255.
//  sensor_debounce sub-module: synchroniser + polarity + debounce, output 'light'.
//    Reusable for other front-panel inputs.
//  lag_capture: FSM, capture regs, stats.
// TESTING
//  T1 start, sensor inactive; flash (light) when bcdcount=20'h01234, held 2 us
//     -> lag_valid 1 cycle, lag_bcd=20'h01234, sample_count=1, busy=0.
//  T2 sensor active at start; release at 20'h00100; flash at 20'h00500
//     -> state passes WAIT_RELEASE, lag_bcd=20'h00500.
//  T3 armed, 10 clock glitch pulses on sensor, no real flash; bcdcount driven to 20'h99999
//     -> no capture, timeout=1, sample_count unchanged.
//     Next start clears timeout.
//  T4 start and debounced edge in same cycle
//     -> no lag_valid, state ARMED, following flash at 20'h00042 captured.
//  T5 LAG_MINMAX_EN: captures 20'h03000, 20'h01500, 20'h04250
//     -> min_bcd=20'h01500, max_bcd=20'h04250.
//     Without macro both read 0.
//  T6 300 captures -> sample_count=255.
//     Then assert reset mid-ARMED -> all outputs reset values within same cycle.

Source files
------------

// File: rtl/lag_pkg.sv
// Shared types and constants for the lag measurement path.
package lag_pkg;

  localparam logic [19:0] BCD_MAX    = 20'h99999;
  localparam logic [7:0]  SAMPLE_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    ARMED,
    DONE
  } lag_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Front-panel input conditioner: 2-FF synchroniser, polarity normalisation
// and debounce. 'light' is the accepted level, active-high.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 27,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic light
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_PIN = ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          raw_light;
  logic [CW-1:0] stable_cnt;

  // Two-stage synchroniser, reset to the pin's inactive level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so 1 always means light detected
  always_comb begin
    raw_light = ACTIVE_LOW ? ~sync2 : sync2;
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample equal to the current level restarts the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      light      <= 1'b0;
    end else if (raw_light == light) begin
      stable_cnt <= '0;
    end else if (stable_cnt == LAST) begin
      stable_cnt <= '0;
      light      <= raw_light;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lag_capture.sv
// Display lag capture: latches the BCD lag count on the first debounced
// flash after each test-frame start, with timeout and sample statistics.
// Optional feature: define LAG_MINMAX_EN to track min/max captured lag.
module lag_capture
  import lag_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 27,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b1,
  parameter logic [19:0] TIMEOUT_BCD       = BCD_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sensor,
  input  logic [19:0] bcdcount,
  output logic [19:0] lag_bcd,
  output logic        lag_valid,
  output logic        timeout,
  output logic        busy,
  output logic [7:0]  sample_count,
  output logic [19:0] min_bcd,
  output logic [19:0] max_bcd
);

  lag_state_t state;
  logic       light;
  logic       light_q;
  logic       rise;
  logic       cap_en;
  logic       expired;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (SENSOR_ACTIVE_LOW)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .pin   (sensor),
    .light (light)
  );

  // Edge/timeout qualification; start always takes priority over a capture
  always_comb begin
    rise    = light & ~light_q;
    expired = (bcdcount >= TIMEOUT_BCD);
    cap_en  = ~start && (state == ARMED) && rise;
  end

  // Measurement FSM with registered outputs.
  // The start decision uses the previous debounced level: a flash whose edge
  // coincides with start is treated as not yet lit, so the restart lands in
  // ARMED and that edge is consumed without capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      light_q   <= 1'b0;
      lag_bcd   <= '0;
      lag_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      light_q   <= light;
      lag_valid <= 1'b0;
      if (start) begin
        timeout <= 1'b0;
        busy    <= 1'b1;
        state   <= light_q ? WAIT_RELEASE : ARMED;
      end else begin
        case (state)
          WAIT_RELEASE: begin
            if (expired) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else if (!light) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (cap_en) begin
              lag_bcd   <= bcdcount;
              lag_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else if (expired) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating count of valid captures
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
    end else if (cap_en && (sample_count != SAMPLE_MAX)) begin
      sample_count <= sample_count + 8'd1;
    end
  end

`ifdef LAG_MINMAX_EN
  // Running min/max of captured lags, updated alongside lag_bcd
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_bcd <= BCD_MAX;
      max_bcd <= '0;
    end else if (cap_en) begin
      if (bcdcount < min_bcd) min_bcd <= bcdcount;
      if (bcdcount > max_bcd) max_bcd <= bcdcount;
    end
  end
`else
  assign min_bcd = '0;
  assign max_bcd = '0;
`endif

endmodule

// File: tb/tb_lag_capture.sv
// Directed testbench for lag_capture (sensor active-low, 27-cycle debounce).
module tb_lag_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sensor;
  logic [19:0] bcdcount;
  logic [19:0] lag_bcd;
  logic        lag_valid;
  logic        timeout;
  logic        busy;
  logic [7:0]  sample_count;
  logic [19:0] min_bcd;
  logic [19:0] max_bcd;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

`ifdef LAG_MINMAX_EN
  localparam logic [19:0] MIN_RST = 20'h99999;
  localparam bit          MM_ON   = 1'b1;
`else
  localparam logic [19:0] MIN_RST = 20'h00000;
  localparam bit          MM_ON   = 1'b0;
`endif

  always #10 clock = ~clock;

  lag_capture #(
    .DEBOUNCE_CYCLES   (27),
    .SENSOR_ACTIVE_LOW (1'b1),
    .TIMEOUT_BCD       (20'h99999)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .sensor       (sensor),
    .bcdcount     (bcdcount),
    .lag_bcd      (lag_bcd),
    .lag_valid    (lag_valid),
    .timeout      (timeout),
    .busy         (busy),
    .sample_count (sample_count),
    .min_bcd      (min_bcd),
    .max_bcd      (max_bcd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge; counts lag_valid pulses
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (lag_valid === 1'b1) vcnt++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    run(1);
    start = 1'b0;
  endtask

  task automatic capture(input logic [19:0] val);
    pulse_start();
    bcdcount = val;
    sensor   = 1'b0;
    run(40);
    sensor   = 1'b1;
    run(40);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lag"},   {12'd0, lag_bcd}, 32'h0);
    check({tag, "_valid"}, {31'd0, lag_valid}, 32'h0);
    check({tag, "_tmo"},   {31'd0, timeout}, 32'h0);
    check({tag, "_busy"},  {31'd0, busy}, 32'h0);
    check({tag, "_cnt"},   {24'd0, sample_count}, 32'h0);
    check({tag, "_min"},   {12'd0, min_bcd}, {12'd0, MIN_RST});
    check({tag, "_max"},   {12'd0, max_bcd}, 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    sensor   = 1'b1;
    bcdcount = '0;
    run(3);
    check_reset_vals("rst");
    reset = 1'b0;
    run(5);

    // T1: plain capture, flash held ~2 us
    pulse_start();
    check("t1_busy_armed", {31'd0, busy}, 32'h1);
    bcdcount = 20'h01234;
    vcnt     = 0;
    sensor   = 1'b0;
    run(54);
    check("t1_valid_pulses", vcnt, 1);
    check("t1_lag", {12'd0, lag_bcd}, 32'h01234);
    check("t1_cnt", {24'd0, sample_count}, 32'd1);
    check("t1_busy_done", {31'd0, busy}, 32'h0);
    sensor = 1'b1;
    run(40);

    // Extra flash in DONE is ignored
    vcnt   = 0;
    sensor = 1'b0;
    run(40);
    check("done_flash_ignored", vcnt, 0);
    check("done_cnt", {24'd0, sample_count}, 32'd1);

    // T2: sensor already lit at start, release then flash
    bcdcount = 20'h00050;
    pulse_start();
    check("t2_busy", {31'd0, busy}, 32'h1);
    bcdcount = 20'h00100;
    sensor   = 1'b1;
    run(40);
    check("t2_no_cap_on_release", vcnt, 0);
    check("t2_busy_armed", {31'd0, busy}, 32'h1);
    bcdcount = 20'h00500;
    sensor   = 1'b0;
    run(40);
    check("t2_valid", vcnt, 1);
    check("t2_lag", {12'd0, lag_bcd}, 32'h00500);
    check("t2_cnt", {24'd0, sample_count}, 32'd2);
    sensor = 1'b1;
    run(40);

    // T3: glitches shorter than debounce, then timeout at the boundary
    bcdcount = 20'h00010;
    pulse_start();
    vcnt = 0;
    for (int g = 0; g < 3; g++) begin
      sensor = 1'b0;
      run(10);
      sensor = 1'b1;
      run(10);
    end
    check("t3_glitch_no_cap", vcnt, 0);
    check("t3_busy", {31'd0, busy}, 32'h1);
    bcdcount = 20'h99998;
    run(3);
    check("t3_below_limit", {31'd0, timeout}, 32'h0);
    bcdcount = 20'h99999;
    run(1);
    check("t3_timeout", {31'd0, timeout}, 32'h1);
    check("t3_busy_done", {31'd0, busy}, 32'h0);
    run(5);
    check("t3_sticky", {31'd0, timeout}, 32'h1);
    check("t3_cnt", {24'd0, sample_count}, 32'd2);
    check("t3_lag_held", {12'd0, lag_bcd}, 32'h00500);
    check("t3_no_valid", vcnt, 0);
    bcdcount = '0;
    pulse_start();
    check("t3_start_clears", {31'd0, timeout}, 32'h0);
    check("t3_rearm_busy", {31'd0, busy}, 32'h1);

    // T4: debounced edge coincides with start; start wins
    bcdcount = 20'h00007;
    vcnt     = 0;
    sensor   = 1'b0;
    run(29);
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(40);
    check("t4_no_valid", vcnt, 0);
    check("t4_armed", {31'd0, busy}, 32'h1);
    sensor = 1'b1;
    run(40);
    bcdcount = 20'h00042;
    sensor   = 1'b0;
    run(40);
    check("t4_valid", vcnt, 1);
    check("t4_lag", {12'd0, lag_bcd}, 32'h00042);
    check("t4_cnt", {24'd0, sample_count}, 32'd3);
    sensor = 1'b1;
    run(40);

    // T5: min/max from a fresh reset
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(5);
    check("t5_cnt_reset", {24'd0, sample_count}, 32'd0);
    capture(20'h03000);
    check("t5_lag0", {12'd0, lag_bcd}, 32'h03000);
    capture(20'h01500);
    check("t5_lag1", {12'd0, lag_bcd}, 32'h01500);
    capture(20'h04250);
    check("t5_lag2", {12'd0, lag_bcd}, 32'h04250);
    check("t5_min", {12'd0, min_bcd}, MM_ON ? 32'h01500 : 32'h0);
    check("t5_max", {12'd0, max_bcd}, MM_ON ? 32'h04250 : 32'h0);
    check("t5_cnt", {24'd0, sample_count}, 32'd3);

    // T6: saturation of sample_count
    for (int i = 0; i < 300; i++) begin
      capture(20'h02000);
      if (i == 250) check("t6_cnt_254", {24'd0, sample_count}, 32'd254);
      if (i == 251) check("t6_cnt_255", {24'd0, sample_count}, 32'd255);
    end
    check("t6_cnt_sat", {24'd0, sample_count}, 32'd255);
    check("t6_min", {12'd0, min_bcd}, MM_ON ? 32'h01500 : 32'h0);

    // Asynchronous reset while armed
    pulse_start();
    bcdcount = 20'h00321;
    run(5);
    check("t6_armed", {31'd0, busy}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    run(3);
    reset = 1'b0;
    run(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
